// File: rtl/tlc_pkg.sv
// Shared types and helpers for the two-way traffic light controller.
// State encodings, per-state lamp vectors, phase durations and the phase order.
package tlc_pkg;

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL  = 3'd1,
    RED_AB = 3'd2,
    B_GRN  = 3'd3,
    B_YEL  = 3'd4,
    RED_BA = 3'd5
  } tlc_state_e;

  typedef struct packed {
    logic r;
    logic g;
    logic y;
  } lamp_t;

  typedef struct packed {
    lamp_t a;
    lamp_t b;
  } lamp_pair_t;

  localparam lamp_t LAMP_RED = 3'b100;
  localparam lamp_t LAMP_GRN = 3'b010;
  localparam lamp_t LAMP_YEL = 3'b001;

  // Unused encodings fall back to all-red so no decode can ever show a green.
  function automatic lamp_pair_t lamps_of(input tlc_state_e s);
    lamp_pair_t lp;
    lp.a = LAMP_RED;
    lp.b = LAMP_RED;
    case (s)
      A_GRN:   lp.a = LAMP_GRN;
      A_YEL:   lp.a = LAMP_YEL;
      B_GRN:   lp.b = LAMP_GRN;
      B_YEL:   lp.b = LAMP_YEL;
      default: ;
    endcase
    return lp;
  endfunction

  function automatic int unsigned dur(input tlc_state_e s, input int unsigned g,
                                      input int unsigned y, input int unsigned r);
    int unsigned d;
    case (s)
      A_GRN, B_GRN: d = g;
      A_YEL, B_YEL: d = y;
      default:      d = r;
    endcase
    return d;
  endfunction

  function automatic tlc_state_e next_of(input tlc_state_e s);
    tlc_state_e n;
    case (s)
      A_GRN:   n = A_YEL;
      A_YEL:   n = RED_AB;
      RED_AB:  n = B_GRN;
      B_GRN:   n = B_YEL;
      B_YEL:   n = RED_BA;
      default: n = A_GRN;
    endcase
    return n;
  endfunction

  function automatic int unsigned max3(input int unsigned x, input int unsigned y,
                                       input int unsigned z);
    int unsigned m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Loadable down-counter timing one light phase; o_zero marks the last cycle of the phase.
module tlc_phase_timer #(
  parameter int         W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Fixed-time two-way traffic light FSM with all-red guard phases between greens.
// Optional TLC_SENSOR_EN adds b_req: A green is extended until E-W traffic waits.
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned GREEN_CYC  = 30,
  parameter int unsigned YELLOW_CYC = 15,
  parameter int unsigned ALLRED_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
`ifdef TLC_SENSOR_EN
  input  logic       b_req,
`endif
  output logic       ar,
  output logic       ag,
  output logic       ay,
  output logic       br,
  output logic       bg,
  output logic       by,
  output logic [2:0] phase,
  output logic       phase_start
);

  localparam int unsigned MAX_CYC = max3(GREEN_CYC, YELLOW_CYC, ALLRED_CYC);
  localparam int          TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] RST_TMR = TW'(ALLRED_CYC - 1);

  tlc_state_e    r_state;
  lamp_pair_t    r_lamps;
  logic          r_phase_start;

  tlc_state_e    w_next;
  lamp_pair_t    w_lamps;
  logic          w_zero;
  logic          w_hold;
  logic          w_adv;
  logic          w_dec;
  logic [TW-1:0] w_load_val;

  tlc_phase_timer #(
    .W       (TW),
    .RST_VAL (RST_TMR)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_adv),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Timer expiry moves the FSM; a held A green parks the timer at zero.
  always_comb begin
    w_hold     = 1'b0;
`ifdef TLC_SENSOR_EN
    w_hold     = (r_state == A_GRN) && !b_req;
`endif
    w_adv      = en && w_zero && !w_hold;
    w_dec      = en && !w_zero;
    w_next     = w_adv ? next_of(r_state) : r_state;
    w_load_val = TW'(dur(next_of(r_state), GREEN_CYC, YELLOW_CYC, ALLRED_CYC) - 1);
    w_lamps    = lamps_of(w_next);
  end

  // Lamps decode the next state so they switch on the same edge as phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RED_BA;
      r_lamps       <= lamps_of(RED_BA);
      r_phase_start <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_lamps       <= w_lamps;
      r_phase_start <= w_adv;
    end
  end

  assign ar          = r_lamps.a.r;
  assign ag          = r_lamps.a.g;
  assign ay          = r_lamps.a.y;
  assign br          = r_lamps.b.r;
  assign bg          = r_lamps.b.g;
  assign by          = r_lamps.b.y;
  assign phase       = r_state;
  assign phase_start = r_phase_start;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: reference model of phase/remaining-cycle counts plus directed checks.
module tb_traffic_light_ctrl;

  localparam int G = 4;
  localparam int Y = 2;
  localparam int R = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, b_req;
  logic       ar, ag, ay, br, bg, by, ps;
  logic [2:0] phase;

  logic       rst2_n, en2, b_req2;
  logic       ar2, ag2, ay2, br2, bg2, by2, ps2;
  logic [2:0] phase2;

  traffic_light_ctrl #(.GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(R)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef TLC_SENSOR_EN
    .b_req(b_req),
`endif
    .ar(ar), .ag(ag), .ay(ay), .br(br), .bg(bg), .by(by),
    .phase(phase), .phase_start(ps)
  );

  traffic_light_ctrl dut_def (
    .clk(clk), .rst_n(rst2_n), .en(en2),
`ifdef TLC_SENSOR_EN
    .b_req(b_req2),
`endif
    .ar(ar2), .ag(ag2), .ay(ay2), .br(br2), .bg(bg2), .by(by2),
    .phase(phase2), .phase_start(ps2)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Phase index 0..5 follows the rotation A green, A yellow, red, B green, B yellow, red.
  function automatic int dur_of(input int p);
    return (p == 0 || p == 3) ? G : (p == 1 || p == 4) ? Y : R;
  endfunction

  // {ar,ag,ay,br,bg,by}
  function automatic logic [5:0] lamps_of_ph(input int p);
    case (p)
      0:       return 6'b010_100;
      1:       return 6'b001_100;
      3:       return 6'b100_010;
      4:       return 6'b100_001;
      default: return 6'b100_100;
    endcase
  endfunction

  int m_ph, m_left;
  bit m_ps;
  bit m_hold;
  bit mdl_on = 1'b0;

  always_comb begin
    m_hold = 1'b0;
`ifdef TLC_SENSOR_EN
    m_hold = (m_ph == 0) && !b_req;
`endif
  end

  // m_left counts the enabled cycles still to spend in the current phase, this one included.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   <= 5;
      m_left <= R;
      m_ps   <= 1'b0;
    end else if (!en) begin
      m_ps <= 1'b0;
    end else if (m_left > 1) begin
      m_left <= m_left - 1;
      m_ps   <= 1'b0;
    end else if (m_hold) begin
      m_ps <= 1'b0;
    end else begin
      m_ph   <= (m_ph + 1) % 6;
      m_left <= dur_of((m_ph + 1) % 6);
      m_ps   <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("model_lamps", 32'({ar, ag, ay, br, bg, by}), 32'(lamps_of_ph(m_ph)));
      chk("model_phase", 32'(phase), m_ph);
      chk("model_phase_start", 32'(ps), 32'(m_ps));
      chk("inv_no_dual_green", 32'(ag & bg), 0);
      chk("inv_a_go_b_red", 32'((ag | ay) & ~br), 0);
      chk("inv_b_go_a_red", 32'((bg | by) & ~ar), 0);
      chk("inv_onehot_a", $countones({ar, ag, ay}), 1);
      chk("inv_onehot_b", $countones({br, bg, by}), 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int seq[14] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5};
  int pscnt, k, g_cnt, y_cnt, n_cnt;

  initial begin
    rst_n = 1'b0; en = 1'b0; b_req = 1'b1;
    rst2_n = 1'b0; en2 = 1'b1; b_req2 = 1'b1;
    mdl_on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ar", 32'(ar), 1);
    chk("rst_br", 32'(br), 1);
    chk("rst_ag", 32'(ag), 0);
    chk("rst_phase", 32'(phase), 5);
    chk("rst_ps", 32'(ps), 0);

    rst_n = 1'b1; en = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    chk("rel_ag", 32'(ag), 1);
    chk("rel_phase", 32'(phase), 0);
    chk("rel_ps", 32'(ps), 1);

    // Full fixed period starting on the first A green cycle.
    pscnt = 0;
    for (int i = 0; i < 14; i++) begin
      chk("seq_phase", 32'(phase), seq[i]);
      pscnt += int'(ps);
      @(negedge clk);
    end
    chk("period_ps_count", pscnt, 6);
    chk("wrap_phase", 32'(phase), 0);
    chk("wrap_ps", 32'(ps), 1);

    // Freeze after two enabled A green cycles.
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("frz_phase", 32'(phase), 0);
      chk("frz_ag", 32'(ag), 1);
      chk("frz_ps", 32'(ps), 0);
    end
    en = 1'b1;
    chk("resume0_phase", 32'(phase), 0);
    @(negedge clk);
    chk("resume1_phase", 32'(phase), 0);
    @(negedge clk);
    chk("resume2_phase", 32'(phase), 1);
    chk("resume2_ps", 32'(ps), 1);

    // Asynchronous reset in the middle of B green.
    k = 0;
    while (phase != 3'd3 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("find_b_grn", 32'(phase), 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ar", 32'(ar), 1);
    chk("mid_rst_br", 32'(br), 1);
    chk("mid_rst_bg", 32'(bg), 0);
    chk("mid_rst_phase", 32'(phase), 5);
    chk("mid_rst_ps", 32'(ps), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ag", 32'(ag), 1);
    chk("mid_rel_phase", 32'(phase), 0);

    // Random enable soak; the model and invariants check every cycle.
    repeat (10000) begin
      en = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    en = 1'b1;

`ifdef TLC_SENSOR_EN
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b_req = 1'b0;
    k = 0;
    while (phase != 3'd0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 25; i++) begin
      chk("sens_hold_phase", 32'(phase), 0);
      @(negedge clk);
    end
    b_req = 1'b1;
    @(negedge clk);
    chk("sens_go_phase", 32'(phase), 1);
    chk("sens_go_ps", 32'(ps), 1);
    repeat (20) @(negedge clk);
`endif

    // Default parameters: measure one period from an A green start.
    k = 0;
    while (!(ps2 && phase2 == 3'd0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("def_find_start", 32'({ps2, phase2}), 32'({1'b1, 3'd0}));
    g_cnt = 0; y_cnt = 0; n_cnt = 0;
    do begin
      g_cnt += int'(ag2);
      y_cnt += int'(ay2);
      n_cnt++;
      @(negedge clk);
    end while (!(ps2 && phase2 == 3'd0) && n_cnt < 300);
    chk("def_green_len", g_cnt, 30);
    chk("def_yellow_len", y_cnt, 15);
    chk("def_period", n_cnt, 94);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
